// File: rtl/pdm_delay_sum_beamformer.sv
`default_nettype none
// ============================================================================
// Module   : pdm_delay_sum_beamformer
// Brief    : Delay-and-sum beamformer for stereo-pair PDM mic arrays. Generates
//            the mic clock, captures two mics per data line, applies per-mic
//            integer-frame steering delays, popcounts and boxcar-decimates.
//            Optional peak-hold output enabled by macro BF_PEAK_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_delay_sum_beamformer #(
  parameter int N_LINES   = 8,
  parameter int HALF_DIV  = 4,
  parameter int MAX_DELAY = 15,
  parameter int DECIM     = 8,
  localparam int OUT_W    = $clog2(2 * N_LINES * DECIM + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [N_LINES-1:0]             pdm_data,
  output logic                           pdm_clk,
  input  logic                           cfg_we,
  input  logic [$clog2(2*N_LINES)-1:0]   cfg_addr,
  input  logic [7:0]                     cfg_delay,
  output logic [OUT_W-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           overrun,
  input  logic                           overrun_clr
`ifdef BF_PEAK_HOLD_EN
  ,
  output logic [OUT_W-1:0]               peak,
  input  logic                           peak_clr
`endif
);

  localparam int c_NM  = 2 * N_LINES;
  localparam int c_DVW = $clog2(HALF_DIV);
  localparam int c_DW  = $clog2(MAX_DELAY + 1);
  localparam int c_CW  = $clog2(c_NM + 1);
  localparam int c_DCW = $clog2(DECIM);
  localparam logic [c_DVW-1:0] c_DIV_TC = c_DVW'(HALF_DIV - 1);
  localparam logic [c_DCW-1:0] c_DEC_TC = c_DCW'(DECIM - 1);

  // ---------------------------------------------------------------- divider
  logic [c_DVW-1:0] r_div;
  logic             r_pdm_clk;
  logic             w_tick;

  assign w_tick  = en && (r_div == c_DIV_TC);
  assign pdm_clk = r_pdm_clk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_div     <= '0;
      r_pdm_clk <= 1'b0;
    end else if (w_tick) begin
      r_div     <= '0;
      r_pdm_clk <= ~r_pdm_clk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // ---------------------------------------------------------------- capture
  logic [N_LINES-1:0] r_odd;
  logic [c_NM-1:0]    w_frame;
  logic [c_NM-1:0]    r_frame;
  logic               r_frame_v;

  for (genvar k = 0; k < N_LINES; k++) begin : g_ilv
    assign w_frame[2*k]   = pdm_data[k];
    assign w_frame[2*k+1] = r_odd[k];
  end

  // The falling toggle samples the even mics and closes the frame.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_odd     <= '0;
      r_frame   <= '0;
      r_frame_v <= 1'b0;
    end else begin
      r_frame_v <= 1'b0;
      if (w_tick) begin
        if (!r_pdm_clk) begin
          r_odd <= pdm_data;
        end else begin
          r_frame   <= w_frame;
          r_frame_v <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------- steering delays
  logic [c_DW-1:0] r_delay [c_NM];
  logic [c_DW-1:0] w_dsat;

  assign w_dsat = (32'(cfg_delay) > MAX_DELAY) ? c_DW'(MAX_DELAY) : c_DW'(cfg_delay);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < c_NM; m++) r_delay[m] <= '0;
    end else if (cfg_we && (32'(cfg_addr) < c_NM)) begin
      r_delay[cfg_addr] <= w_dsat;
    end
  end

  // ------------------------------------------------------------ delay lines
  logic [MAX_DELAY:0] r_dl [c_NM];
  logic               r_shift_v;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      for (int m = 0; m < c_NM; m++) r_dl[m] <= '0;
      r_shift_v <= 1'b0;
    end else begin
      r_shift_v <= r_frame_v;
      if (r_frame_v) begin
        for (int m = 0; m < c_NM; m++) r_dl[m] <= {r_dl[m][MAX_DELAY-1:0], r_frame[m]};
      end
    end
  end

  // ------------------------------------------------------- tap and popcount
  logic [c_NM-1:0] w_tap;
  logic [c_CW-1:0] w_cnt;
  logic [c_CW-1:0] r_cnt;
  logic            r_cnt_v;

  for (genvar m = 0; m < c_NM; m++) begin : g_tap
    assign w_tap[m] = r_dl[m][r_delay[m]];
  end

  always_comb begin
    w_cnt = '0;
    for (int m = 0; m < c_NM; m++) w_cnt = w_cnt + c_CW'(w_tap[m]);
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt   <= '0;
      r_cnt_v <= 1'b0;
    end else begin
      r_cnt_v <= r_shift_v;
      if (r_shift_v) r_cnt <= w_cnt;
    end
  end

  // -------------------------------------------------------------- decimator
  logic [c_DCW-1:0] r_dcnt;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] w_sum;
  logic             w_load;

  assign w_sum  = r_acc + OUT_W'(r_cnt);
  assign w_load = en && r_cnt_v && (r_dcnt == c_DEC_TC);

  // The last frame of a window goes straight to the output so the
  // accumulator can restart without dropping a frame.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_dcnt <= '0;
      r_acc  <= '0;
    end else if (r_cnt_v) begin
      if (r_dcnt == c_DEC_TC) begin
        r_dcnt <= '0;
        r_acc  <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
        r_acc  <= w_sum;
      end
    end
  end

  // -------------------------------------------------------- output register
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= w_sum;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_load && r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef BF_PEAK_HOLD_EN
  logic [OUT_W-1:0] r_peak;

  assign peak = r_peak;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_peak <= '0;
    end else if (peak_clr) begin
      r_peak <= w_load ? w_sum : '0;
    end else if (w_load && (w_sum > r_peak)) begin
      r_peak <= w_sum;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pdm_delay_sum_beamformer.sv
`default_nettype none
// Testbench for pdm_delay_sum_beamformer: random and directed PDM stimulus
// compared cycle by cycle against a frame-level arithmetic model.
module tb_pdm_delay_sum_beamformer;

  localparam int N_LINES   = 8;
  localparam int HALF_DIV  = 4;
  localparam int MAX_DELAY = 15;
  localparam int DECIM     = 8;
  localparam int NM        = 2 * N_LINES;
  localparam int PER       = 2 * HALF_DIV;
  localparam int WIN       = PER * DECIM;
  localparam int OUT_W     = $clog2(NM * DECIM + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic [N_LINES-1:0] pdm_data = '0;
  logic               pdm_clk;
  logic               cfg_we = 1'b0;
  logic [3:0]         cfg_addr = '0;
  logic [7:0]         cfg_delay = '0;
  logic [OUT_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               overrun;
  logic               overrun_clr = 1'b0;
`ifdef BF_PEAK_HOLD_EN
  logic [OUT_W-1:0]   peak;
  logic               peak_clr = 1'b0;
`endif

  pdm_delay_sum_beamformer #(
    .N_LINES(N_LINES), .HALF_DIV(HALF_DIV), .MAX_DELAY(MAX_DELAY), .DECIM(DECIM)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pdm_data(pdm_data), .pdm_clk(pdm_clk),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef BF_PEAK_HOLD_EN
    , .peak(peak), .peak_clr(peak_clr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: frames as 16-bit words, output j = sum over its window.
  int               k = 0;
  logic [NM-1:0]    frames[$];
  logic [N_LINES-1:0] m_odd = '0;
  int               dly[NM];
  bit               ev = 0;
  bit               eo = 0;
  int               ed = 0;
  int               epk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t edge=%0d: got=%0d expected=%0d", tag, $time, k, got, exp);
    end
  endtask

  function automatic logic [NM-1:0] ilv(input logic [N_LINES-1:0] ev_bits, input logic [N_LINES-1:0] od_bits);
    logic [NM-1:0] f;
    for (int i = 0; i < N_LINES; i++) begin
      f[2*i]   = ev_bits[i];
      f[2*i+1] = od_bits[i];
    end
    return f;
  endfunction

  function automatic int exp_out(input int j);
    int s = 0;
    for (int f = j * DECIM; f < (j + 1) * DECIM; f++)
      for (int m = 0; m < NM; m++) begin
        int idx = f - dly[m];
        if (idx >= 0) s += int'(frames[idx][m]);
      end
    return s;
  endfunction

  // One clk edge: drive, update model, compare every observable output.
  task automatic step(input logic [N_LINES-1:0] din, input bit rdy, input bit clr);
    bit load = 0;
    bit set_ov;
    int nd = 0;
    pdm_data    = din;
    out_ready   = rdy;
    overrun_clr = clr;
    @(posedge clk);
    if (rst) begin
      k = 0; frames.delete(); ev = 0; eo = 0; ed = 0; epk = 0;
      for (int m = 0; m < NM; m++) dly[m] = 0;
    end else begin
      if (cfg_we) dly[cfg_addr] = (int'(cfg_delay) > MAX_DELAY) ? MAX_DELAY : int'(cfg_delay);
      if (en) begin
        k++;
        if (k % PER == HALF_DIV) m_odd = din;
        if (k % PER == 0) frames.push_back(ilv(din, m_odd));
        if (k > 3 && (k - 3) % WIN == 0) begin
          load = 1;
          nd = exp_out((k - 3) / WIN - 1);
        end
      end else begin
        k = 0;
        frames.delete();
      end
      set_ov = load && ev && !rdy;
      if (load) begin ev = 1; ed = nd; end
      else if (ev && rdy) ev = 0;
      if (set_ov) eo = 1;
      else if (clr) eo = 0;
`ifdef BF_PEAK_HOLD_EN
      if (peak_clr) epk = load ? nd : 0;
      else if (load && nd > epk) epk = nd;
`endif
    end
    #1;
    check("pdm_clk", pdm_clk, (!rst && en && (k % PER >= HALF_DIV)) ? 1 : 0);
    check("out_valid", out_valid, ev);
    check("out_data", out_data, ed);
    check("overrun", overrun, eo);
`ifdef BF_PEAK_HOLD_EN
    check("peak", peak, epk);
`endif
  endtask

  task automatic idle(input int n);
    en = 0;
    for (int i = 0; i < n; i++) step('0, 1, 0);
  endtask

  task automatic cfg_wr(input int a, input int v);
    cfg_we = 1; cfg_addr = 4'(a); cfg_delay = 8'(v);
    idle(1);
    cfg_we = 0;
  endtask

  // md: 0 all ones, 1 all zeros, 2 random, 3 full-frame impulse, 4 mic-0 impulse
  task automatic run(input int nedges, input int md, input int imp);
    en = 1;
    for (int i = 0; i < nedges; i++) begin
      int kn = k + 1;
      int fr = (kn - 1) / PER;
      logic [N_LINES-1:0] d;
      case (md)
        0: d = '1;
        1: d = '0;
        2: d = N_LINES'($urandom);
        3: d = (fr == imp) ? '1 : '0;
        default: d = (fr == imp && kn % PER == 0) ? N_LINES'(1) : '0;
      endcase
      step(d, 1, 0);
    end
  endtask

  initial begin
    rst = 1;
    idle(2);
    rst = 0;
    idle(2);

    // Constant ones and zeros, delays 0
    run(3 * WIN + 4, 0, 0);
    idle(2);
    run(2 * WIN + 4, 1, 0);
    idle(2);

    // Random delays (some saturating) and random data
    for (int m = 0; m < NM; m++) cfg_wr(m, $urandom_range(0, 40));
    run(4 * WIN + 4, 2, 0);
    idle(2);

    // Delay m = m, one all-ones frame
    for (int m = 0; m < NM; m++) cfg_wr(m, m);
    run(3 * WIN + 4, 3, 0);

    // Mid-run reset clears delays and pipeline
    run(50, 2, 0);
    rst = 1;
    step(8'hA5, 1, 0);
    rst = 0;
    run(WIN + 4, 0, 0);
    idle(2);

    // Saturating delay on mic 0, impulse on mic 0 only
    cfg_wr(0, 40);
    run(3 * WIN + 4, 4, 2);
    idle(2);

    // Overrun, clear, set-wins, simultaneous load+ready, drop on ready
    for (int m = 0; m < NM; m++) cfg_wr(m, $urandom_range(0, 15));
    en = 1;
    for (int i = 0; i < 4 * WIN + 8; i++) begin
      int kn = k + 1;
      bit rdy = (kn == 4 * WIN + 3) || (kn > 4 * WIN + 3);
      bit clr = (kn == 2 * WIN + 4) || (kn == 3 * WIN + 3) || (kn == 3 * WIN + 4);
      step(N_LINES'($urandom), rdy, clr);
    end
    idle(2);

    // Disable after 5 frames: window restarts from scratch on re-enable
    for (int m = 0; m < NM; m++) cfg_wr(m, 0);
    run(5 * PER, 0, 0);
    idle(3);
    run(WIN + 4, 0, 0);
    idle(2);
`ifdef BF_PEAK_HOLD_EN
    peak_clr = 1;
    idle(1);
    peak_clr = 0;
    idle(1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
